// File: rtl/lsu_mem_master_pkg.sv
// Shared definitions for the load/store memory master: funct3 codes, FSM states
// and the fixed word access size presented to data memory.
package lsu_mem_master_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ACCESS_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    // Byte count touched by an access; unknown codes are sized as a word so the
    // range check stays conservative (they are flagged illegal anyway).
    function automatic logic [2:0] access_bytes(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: access_bytes = 3'd1;
            F3_H, F3_HU: access_bytes = 3'd2;
            default:     access_bytes = 3'd4;
        endcase
    endfunction

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we) f3_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else    f3_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                           (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_mem_master_lane_align.sv
// Byte-lane steering: extracts and extends load data from a memory word, and
// merges narrow store data into the word read back for read-modify-write.
module lsu_lane_align
    import lsu_mem_master_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_word_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[7:0];
        case (addr_lo_i)
            2'd0: byte_sel = word_i[7:0];
            2'd1: byte_sel = word_i[15:8];
            2'd2: byte_sel = word_i[23:16];
            2'd3: byte_sel = word_i[31:24];
            default: byte_sel = word_i[7:0];
        endcase
        half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
    end

    always_comb begin
        load_data_o = word_i;
        case (funct3_i)
            F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data_o = {24'd0, byte_sel};
            F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data_o = {16'd0, half_sel};
            default: load_data_o = word_i;
        endcase
    end

    always_comb begin
        store_word_o = word_i;
        case (funct3_i)
            F3_B: begin
                case (addr_lo_i)
                    2'd0: store_word_o[7:0]   = wdata_i[7:0];
                    2'd1: store_word_o[15:8]  = wdata_i[7:0];
                    2'd2: store_word_o[23:16] = wdata_i[7:0];
                    2'd3: store_word_o[31:24] = wdata_i[7:0];
                    default: store_word_o = word_i;
                endcase
            end
            F3_H: begin
                if (addr_lo_i[1]) store_word_o[31:16] = wdata_i[15:0];
                else              store_word_o[15:0]  = wdata_i[15:0];
            end
            F3_W:    store_word_o = wdata_i;
            default: store_word_o = word_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// MEM-stage load/store initiator: word-only memory port with read-modify-write
// for byte/half stores, load extension, and alignment/range/funct3 checking.
module lsu_mem_master
    import lsu_mem_master_pkg::*;
#(
    parameter logic [31:0] MEM_BASE  = 32'h0100_0000,
    parameter logic [31:0] MEM_BYTES = 32'h0010_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic        mem_read_write,
    output logic [31:0] mem_data_in,
    output logic [1:0]  mem_access_size,
    input  logic [31:0] mem_data_out
);

    lsu_state_e  state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] load_data;
    logic [31:0] store_word;

    logic        misaligned;
    logic        out_of_range;
    logic        illegal_f3;
    logic        req_err;
    logic [32:0] req_end;
    logic [32:0] mem_limit;

    // 33-bit arithmetic so an access near 2^32 cannot wrap into the window.
    always_comb begin
        req_end      = {1'b0, req_addr} + {30'd0, access_bytes(req_funct3)};
        mem_limit    = {1'b0, MEM_BASE} + {1'b0, MEM_BYTES};
        misaligned   = (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && req_addr[0]) ||
                       ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
        out_of_range = (req_addr < MEM_BASE) || (req_end > mem_limit);
        illegal_f3   = !f3_legal(req_we, req_funct3);
        req_err      = misaligned || out_of_range || illegal_f3;
    end

    lsu_lane_align u_lane_align (
        .addr_lo_i    (addr_lo_q),
        .funct3_i     (f3_q),
        .word_i       (mem_data_out),
        .wdata_i      (wdata_q),
        .load_data_o  (load_data),
        .store_word_o (store_word)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            f3_q        <= '0;
            addr_lo_q   <= '0;
            wdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            addr_lo_q   <= addr_lo_d;
            wdata_q     <= wdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        f3_d        = f3_q;
        addr_lo_d   = addr_lo_q;
        wdata_d     = wdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d      = req_we;
                    f3_d      = req_funct3;
                    addr_lo_d = req_addr[1:0];
                    wdata_d   = req_wdata;
                    rdata_d   = '0;
                    err_d     = req_err;
                    // Faulting ops leave the memory port registers untouched.
                    if (req_err) begin
                        state_d = ST_RESP;
                    end else begin
                        mem_addr_d = {req_addr[31:2], 2'b00};
                        if (req_we && (req_funct3 == F3_W)) begin
                            mem_wdata_d = req_wdata;
                            state_d     = ST_WRITE;
                        end else begin
                            state_d = ST_READ;
                        end
                    end
                end
            end
            ST_READ: begin
                if (we_q) begin
                    mem_wdata_d = store_word;
                    state_d     = ST_WRITE;
                end else begin
                    rdata_d = load_data;
                    state_d = ST_RESP;
                end
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign req_ready       = (state_q == ST_IDLE);
    assign resp_valid      = (state_q == ST_RESP);
    assign resp_rdata      = rdata_q;
    assign resp_err        = err_q;
    assign mem_address     = mem_addr_q;
    assign mem_read_write  = (state_q == ST_WRITE);
    assign mem_data_in     = mem_wdata_q;
    assign mem_access_size = ACCESS_WORD;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master against a small word memory model.
module tb_lsu_mem_master;

    localparam logic [2:0] B  = 3'b000;
    localparam logic [2:0] H  = 3'b001;
    localparam logic [2:0] W  = 3'b010;
    localparam logic [2:0] BU = 3'b100;
    localparam logic [2:0] HU = 3'b101;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic        mem_read_write;
    logic [31:0] mem_data_in;
    logic [1:0]  mem_access_size;
    logic [31:0] mem_data_out;

    lsu_mem_master #(
        .MEM_BASE  (32'h0100_0000),
        .MEM_BYTES (32'h0010_0000)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_we          (req_we),
        .req_funct3      (req_funct3),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_err        (resp_err),
        .mem_address     (mem_address),
        .mem_read_write  (mem_read_write),
        .mem_data_in     (mem_data_in),
        .mem_access_size (mem_access_size),
        .mem_data_out    (mem_data_out)
    );

    always #5 clock = ~clock;

    // Word memory model: index by address bits [7:2], preloaded on first edge.
    logic [31:0] mem [0:63];
    bit          init_done = 1'b0;
    assign mem_data_out = mem[mem_address[7:2]];

    always @(posedge clock) begin
        if (!init_done) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[4]    <= 32'h8899_AABB;
            mem[5]    <= 32'h1122_3344;
            mem[63]   <= 32'hCAFE_F00D;
            init_done <= 1'b1;
        end else if (mem_read_write) begin
            mem[mem_address[7:2]] <= mem_data_in;
        end
    end

    typedef struct {
        string       name;
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    exp_t        sbq[$];
    int          accq[$];
    int          resp_log[$];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          wr_cnt = 0;
    logic [31:0] last_wr_data = '0;
    logic [31:0] last_wr_addr = '0;

    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: samples on the falling edge, pairs each response with its accept.
    always @(negedge clock) begin
        if (!reset_n) begin
            accq.delete();
        end else begin
            if (mem_read_write) begin
                wr_cnt++;
                last_wr_data = mem_data_in;
                last_wr_addr = mem_address;
            end
            if (req_valid && req_ready) accq.push_back(cyc);
            if (resp_valid) begin
                resp_log.push_back(cyc);
                if (sbq.size() == 0) begin
                    check("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    int   lat;
                    e   = sbq.pop_front();
                    lat = (accq.size() != 0) ? cyc - accq.pop_front() : -1;
                    check({e.name, "_rdata"}, resp_rdata, e.rdata);
                    check({e.name, "_err"}, {31'd0, resp_err}, {31'd0, e.err});
                    check({e.name, "_lat"}, 32'(lat), 32'(e.lat));
                end
            end
        end
    end

    task automatic issue(input bit push, input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic e_err, input logic [31:0] e_rdata, input int e_lat);
        int n;
        if (push) sbq.push_back('{name, e_err, e_rdata, e_lat});
        @(posedge clock); #1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!req_ready && n < 20);
        if (!req_ready) check({name, "_accept_timeout"}, 32'd0, 32'd1);
        @(posedge clock); #1;
    endtask

    task automatic drain(input string name);
        int n;
        req_valid = 1'b0;
        n = 0;
        while (sbq.size() != 0 && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (sbq.size() != 0) begin
            check({name, "_resp_timeout"}, 32'(sbq.size()), 32'd0);
            sbq.delete();
        end
        @(posedge clock); #1;
    endtask

    initial begin
        int w0;
        int n;
        int r;

        #2;
        check("rst_req_ready",   {31'd0, req_ready},      32'd1);
        check("rst_resp_valid",  {31'd0, resp_valid},     32'd0);
        check("rst_resp_rdata",  resp_rdata,              32'd0);
        check("rst_resp_err",    {31'd0, resp_err},       32'd0);
        check("rst_mem_rw",      {31'd0, mem_read_write}, 32'd0);
        check("rst_mem_address", mem_address,             32'd0);
        check("rst_mem_data_in", mem_data_in,             32'd0);
        check("rst_access_size", {30'd0, mem_access_size}, 32'd2);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        // Loads with lane extraction and extension
        issue(1, "lb_11",  0, B,  32'h0100_0011, 0, 0, 32'hFFFF_FFAA, 2); drain("lb_11");
        issue(1, "lbu_11", 0, BU, 32'h0100_0011, 0, 0, 32'h0000_00AA, 2); drain("lbu_11");
        issue(1, "lh_12",  0, H,  32'h0100_0012, 0, 0, 32'hFFFF_8899, 2); drain("lh_12");
        issue(1, "lhu_12", 0, HU, 32'h0100_0012, 0, 0, 32'h0000_8899, 2); drain("lhu_12");
        issue(1, "lbu_13", 0, BU, 32'h0100_0013, 0, 0, 32'h0000_0088, 2); drain("lbu_13");

        // Byte store: read-modify-write with a single write cycle
        w0 = wr_cnt;
        issue(1, "sb_12", 1, B, 32'h0100_0012, 32'h0000_005C, 0, 32'h0, 3); drain("sb_12");
        check("sb_12_wr_count", 32'(wr_cnt - w0), 32'd1);
        check("sb_12_wr_data",  last_wr_data, 32'h885C_AABB);
        check("sb_12_wr_addr",  last_wr_addr, 32'h0100_0010);
        issue(1, "lw_10", 0, W, 32'h0100_0010, 0, 0, 32'h885C_AABB, 2); drain("lw_10");

        // Upper half store
        w0 = wr_cnt;
        issue(1, "sh_16", 1, H, 32'h0100_0016, 32'h5555_ABCD, 0, 32'h0, 3); drain("sh_16");
        check("sh_16_wr_count", 32'(wr_cnt - w0), 32'd1);
        check("sh_16_wr_data",  last_wr_data, 32'hABCD_3344);

        // Word store: no read phase, one write cycle
        w0 = wr_cnt;
        issue(1, "sw_20", 1, W, 32'h0100_0020, 32'hDEAD_BEEF, 0, 32'h0, 2); drain("sw_20");
        check("sw_20_wr_count", 32'(wr_cnt - w0), 32'd1);
        check("sw_20_wr_data",  last_wr_data, 32'hDEAD_BEEF);
        issue(1, "lw_20", 0, W, 32'h0100_0020, 0, 0, 32'hDEAD_BEEF, 2); drain("lw_20");

        // Error cases: one-cycle response, never a write
        w0 = wr_cnt;
        issue(1, "lw_mis",   0, W,  32'h0100_0002, 0, 1, 32'h0, 1); drain("lw_mis");
        issue(1, "sh_below", 1, H,  32'h00FF_FFFE, 32'h1234, 1, 32'h0, 1); drain("sh_below");
        issue(1, "lh_mis",   0, H,  32'h0100_0011, 0, 1, 32'h0, 1); drain("lh_mis");
        issue(1, "sbu_ill",  1, BU, 32'h0100_0010, 32'hFF, 1, 32'h0, 1); drain("sbu_ill");
        issue(1, "l011_ill", 0, 3'b011, 32'h0100_0010, 0, 1, 32'h0, 1); drain("l011_ill");
        issue(1, "lh_top",   0, H,  32'h010F_FFFF, 0, 1, 32'h0, 1); drain("lh_top");
        issue(1, "lb_past",  0, B,  32'h0110_0000, 0, 1, 32'h0, 1); drain("lb_past");
        issue(1, "sw_past",  1, W,  32'h0110_0000, 32'h1, 1, 32'h0, 1); drain("sw_past");
        check("err_wr_count", 32'(wr_cnt - w0), 32'd0);
        check("err_mem_unchanged", mem[4], 32'h885C_AABB);

        // Upper range boundary: last word/half/byte are legal
        issue(1, "lw_top",  0, W,  32'h010F_FFFC, 0, 0, 32'hCAFE_F00D, 2); drain("lw_top");
        issue(1, "lhu_top", 0, HU, 32'h010F_FFFE, 0, 0, 32'h0000_CAFE, 2); drain("lhu_top");
        issue(1, "lb_top",  0, B,  32'h010F_FFFF, 0, 0, 32'hFFFF_FFCA, 2); drain("lb_top");

        // Reset during the write phase of a half store
        issue(0, "sh_rst", 1, H, 32'h0100_0014, 32'h0000_7777, 0, 32'h0, 3);
        req_valid = 1'b0;
        n = 0;
        while (!mem_read_write && n < 10) begin
            @(negedge clock);
            n++;
        end
        check("rst_wr_reached", {31'd0, mem_read_write}, 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("rst_mid_rw",         {31'd0, mem_read_write}, 32'd0);
        check("rst_mid_ready",      {31'd0, req_ready},      32'd1);
        check("rst_mid_resp_valid", {31'd0, resp_valid},     32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_mem_unchanged", mem[5], 32'hABCD_3344);
        issue(1, "lw_after_rst", 0, W, 32'h0100_0014, 0, 0, 32'hABCD_3344, 2); drain("lw_after_rst");

        // Back-to-back loads with req_valid held high
        r = resp_log.size();
        issue(1, "b2b_0", 0, W,  32'h0100_0010, 0, 0, 32'h885C_AABB, 2);
        issue(1, "b2b_1", 0, W,  32'h0100_0020, 0, 0, 32'hDEAD_BEEF, 2);
        issue(1, "b2b_2", 0, BU, 32'h0100_0021, 0, 0, 32'h0000_00BE, 2);
        drain("b2b");
        check("b2b_resp_count", 32'(resp_log.size() - r), 32'd3);
        if (resp_log.size() - r == 3) begin
            check("b2b_gap_01", 32'(resp_log[r + 1] - resp_log[r]),     32'd3);
            check("b2b_gap_12", 32'(resp_log[r + 2] - resp_log[r + 1]), 32'd3);
        end

        repeat (3) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got time %0t expected completion", $time);
        $fatal(1);
    end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator that drives the data memory port (address, read_write, data_in, access_size; data_out returned combinationally) on behalf of the MEM stage.
- The data memory writes full 32-bit words only. This block therefore performs read-modify-write for SB/SH stores, byte-lane extraction and sign/zero extension for loads, and alignment/range checking.
- Sits between the MEM-stage pipeline register and the data memory. It stalls the pipeline via req_ready until the response is returned.

Parameters:
- MEM_BASE, 32'h0100_0000, first byte address of data memory.
- MEM_BYTES, 32'h0010_0000, size of data memory in bytes; valid range is [MEM_BASE, MEM_BASE+MEM_BYTES).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  pipeline presents a memory op.
- req_ready  out  1  high only in IDLE; op accepted when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are loads only).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data (low bits used for B/H).
- resp_valid  out  1  one-cycle pulse: op complete.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid: misaligned, out of range, or illegal funct3.
- mem_address  out  32  word-aligned address ({addr[31:2],2'b00}).
- mem_read_write  out  1  1 = write, 0 = read.
- mem_data_in  out  32  full word to write.
- mem_access_size  out  2  constant 2'd2 (word); all merging is done here.
- mem_data_out  in  32  combinational read data.

Behaviour:
- Reset (async, reset_n low):
  - state = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0.
  - mem_read_write = 0, mem_address = 0, mem_data_in = 0.
- States: IDLE, READ, WRITE, RESP.
- mem_read_write is decoded combinationally from state (1 only in WRITE). Reset therefore deasserts it immediately, even mid-RMW.
- On accept in IDLE: latch we, funct3, addr, wdata. Evaluate error first:
  - H/HU with addr[0] != 0 is misaligned.
  - W with addr[1:0] != 0 is misaligned.
  - addr < MEM_BASE or addr+size > MEM_BASE+MEM_BYTES is out of range.
  - funct3 not in the legal set for we is illegal.
- Next state from IDLE:
  - Error -> RESP with err = 1; no memory access; mem_read_write never asserted.
  - Load -> READ.
  - SW -> WRITE.
  - SB/SH -> READ.
- READ (1 cycle): mem_address valid, read_write = 0; register mem_data_out at the cycle-end edge.
  - Load: extract lane by addr[1:0], extend (B/H sign-extend, BU/HU zero-extend), then -> RESP.
  - SB/SH: merge wdata[7:0] into byte lane addr[1:0], or wdata[15:0] into half lane addr[1], then -> WRITE.
- WRITE (exactly 1 cycle): address and data held stable for the whole cycle, read_write = 1, then -> RESP.
- RESP (1 cycle): resp_valid = 1, then -> IDLE. req_ready = 0 during RESP, so back-to-back ops are accepted at the earliest one cycle after RESP.
- Latency from accept edge to resp_valid:
  - load: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
  - error: 1 cycle.
- mem_address and mem_data_in hold their last values in IDLE/RESP. Memory sees no write outside WRITE.
- req_valid while not ready is ignored; the requester must hold its request.
- Range boundary: a word at MEM_BASE+MEM_BYTES-4 is legal; a half at MEM_BASE+MEM_BYTES-1 is an error.

Decomposition:
- Shared package holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State encoding constants.
  - ACCESS_WORD = 2'd2.
- One natural sub-module: lsu_lane_align, purely combinational. It computes load extraction/extension and store-lane merge from (addr[1:0], funct3, word, wdata). The FSM stays in the top module.

Test Plan:
- Memory preloaded 0x01000010 = 0x8899AABB; LB at 0x01000011 -> resp after 2 cycles, rdata 0xFFFFFFAA; LBU -> 0x000000AA; LH at 0x01000012 -> 0xFFFF8899.
- SB 0x5C to 0x01000012 over 0x8899AABB -> one READ cycle then exactly one write cycle with mem_data_in 0x885CAABB; subsequent LW -> 0x885CAABB.
- SW 0xDEADBEEF to 0x01000020 -> mem_read_write high exactly one cycle, no read cycle; resp 2 cycles after accept, err 0.
- LW at 0x01000002 (misaligned) and SH at 0x00FFFFFE (below base) -> resp_err 1 after 1 cycle; mem_read_write never asserts; memory unchanged.
- reset_n dropped during WRITE of an SH -> mem_read_write falls asynchronously, no resp_valid, req_ready 1; after release a new LW completes normally.
- Back-to-back: req_valid held high with 3 queued loads -> each accepted only in IDLE, resp_valid pulses spaced 3 cycles apart, data correct.
